mux2_rr_arbiter: RTL and testbench

//  Shares one N-bit output channel between two valid/ready requesters by driving the select of a
//  2:1 datapath mux. Arbitration is round-robin, and each grant lasts for a burst of up to MAX_BURST beats.
//  The output is registered (one holding stage). The block sits in front of any shared

---
 rtl/mux2_rr_arbiter_pkg.sv | 39 +++
 rtl/mux2_rr_arbiter_mux.sv | 13 +
 rtl/mux2_rr_arbiter.sv | 107 ++++++++++
 tb/tb_mux2_rr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux2_rr_arbiter_pkg.sv
// Shared types and helpers for the two-requester round-robin arbiter.
package mux2_rr_arbiter_pkg;

  localparam int DATA_W = 32;
  localparam int BURST  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } beat_t;

  function automatic int cnt_w(input int mb);
    return $clog2(mb) + 1;
  endfunction

  // last names the most recent owner; a tie goes to the other one
  function automatic state_t pick(
    input logic v0,
    input logic v1,
    input logic last
  );
    state_t s;
    s = IDLE;
    unique case (1'b1)
      (v0 & v1):  s = last ? GNT0 : GNT1;
      (v0 & ~v1): s = GNT0;
      (~v0 & v1): s = GNT1;
      default:    s = IDLE;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// Two-input datapath mux; sel=1 passes d1.
module twoto1mux #(
  parameter int n = 32
) (
  input  logic         sel,
  input  logic [n-1:0] d0,
  input  logic [n-1:0] d1,
  output logic [n-1:0] y
);

  assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, burst-limited arbiter sharing one registered
// output channel between two valid/ready requesters.
module mux2_rr_arbiter
  import mux2_rr_arbiter_pkg::*;
#(
  parameter int n         = DATA_W,
  parameter int MAX_BURST = BURST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in0_valid,
  input  logic [n-1:0] in0_data,
  output logic         in0_ready,
  input  logic         in1_valid,
  input  logic [n-1:0] in1_data,
  output logic         in1_ready,
  output logic         out_valid,
  output logic [n-1:0] out_data,
  output logic         out_src,
  input  logic         out_ready
);

  localparam int CW = cnt_w(MAX_BURST);
  localparam logic [CW-1:0] LAST_BEAT = CW'(MAX_BURST - 1);

  state_t        state;
  state_t        st_nxt;
  logic          last;
  logic          last_nxt;
  logic [CW-1:0] beat_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          owner;
  logic          load;
  logic          xfer;
  logic          own_valid;
  logic          rel;
  logic          enter;
  logic [n-1:0]  mux_y;

  twoto1mux #(.n(n)) u_mux (
    .sel (owner),
    .d0  (in0_data),
    .d1  (in1_data),
    .y   (mux_y)
  );

  assign owner     = (state == GNT1);
  assign load      = out_ready | ~out_valid;
  assign in0_ready = (state == GNT0) & load;
  assign in1_ready = (state == GNT1) & load;
  assign own_valid = owner ? in1_valid : in0_valid;
  assign xfer      = (in0_valid & in0_ready)
                   | (in1_valid & in1_ready);

  // a stalled output freezes the grant, so release needs load
  assign rel = load & ((xfer & (beat_cnt == LAST_BEAT))
                       | ~own_valid);

  always_comb begin
    st_nxt   = state;
    last_nxt = last;
    cnt_nxt  = beat_cnt;
    enter    = 1'b0;
    unique case (state)
      IDLE: begin
        st_nxt = pick(in0_valid, in1_valid, last);
        enter  = (st_nxt != IDLE);
      end
      GNT0, GNT1: begin
        if (rel) begin
          st_nxt = pick(in0_valid, in1_valid, owner);
          enter  = (st_nxt != IDLE);
        end else if (xfer) begin
          cnt_nxt = beat_cnt + 1'b1;
        end
      end
      default: st_nxt = IDLE;
    endcase
    if (enter) begin
      last_nxt = (st_nxt == GNT1);
      cnt_nxt  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 1'b1;
      beat_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 1'b0;
    end else begin
      state    <= st_nxt;
      last     <= last_nxt;
      beat_cnt <= cnt_nxt;
      if (load) begin
        out_valid <= xfer;
        if (xfer) begin
          out_data <= mux_y;
          out_src  <= owner;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Self-checking bench for mux2_rr_arbiter: vector table
// for reset/ready timing, scoreboard for every beat.
module tb_mux2_rr_arbiter;
  import mux2_rr_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in0_valid = 1'b0;
  logic [31:0] in0_data = '0;
  logic        in0_ready;
  logic        in1_valid = 1'b0;
  logic [31:0] in1_data = '0;
  logic        in1_ready;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_src;
  logic        out_ready = 1'b1;

  mux2_rr_arbiter #(.n(32), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in0_valid (in0_valid),
    .in0_data  (in0_data),
    .in0_ready (in0_ready),
    .in1_valid (in1_valid),
    .in1_data  (in1_data),
    .in1_ready (in1_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic v0;
    logic v1;
    logic ordy;
    logic r0;
    logic r1;
    logic ov;
  } vec_t;

  vec_t        vec [6];
  beat_t       q [$];
  logic        slog [$];
  logic [31:0] dlog [$];
  int          tlog [$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          cyc_n = 0;
  int          rem0 = 0;
  int          rem1 = 0;
  int          acc1 = 0;
  logic        s_r0, s_r1, s_ov;
  logic [31:0] s_od;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic upd();
    in0_valid = (rem0 != 0);
    in1_valid = (rem1 != 0);
  endtask

  // sample at negedge, then advance requesters after posedge
  task automatic cyc();
    logic r0, r1;
    beat_t e;
    @(negedge clk);
    s_r0 = in0_ready;
    s_r1 = in1_ready;
    s_ov = out_valid;
    s_od = out_data;
    r0 = in0_valid & in0_ready;
    r1 = in1_valid & in1_ready;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        slog.push_back(out_src);
        dlog.push_back(out_data);
        tlog.push_back(cyc_n);
        n_chk++;
        if (q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: got %h, expected no beat", out_data);
        end else begin
          e = q.pop_front();
          if (e.src !== out_src || e.data !== out_data) begin
            n_fail++;
            $display("FAIL sb_beat: got %0d/%h, expected %0d/%h",
                     out_src, out_data, e.src, e.data);
          end
        end
      end
      if (r0) q.push_back('{1'b0, in0_data});
      if (r1) q.push_back('{1'b1, in1_data});
      if (r1) acc1++;
    end
    @(posedge clk);
    #1;
    cyc_n++;
    if (r0) begin
      in0_data = in0_data + 1;
      if (rem0 > 0) rem0--;
    end
    if (r1) begin
      in1_data = in1_data + 1;
      if (rem1 > 0) rem1--;
    end
    upd();
  endtask

  task automatic clr();
    slog.delete();
    dlog.delete();
    tlog.delete();
    acc1 = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    rem0 = 0;
    rem1 = 0;
    out_ready = 1'b1;
    upd();
    cyc();
    cyc();
    rst = 1'b0;
    q.delete();
    clr();
  endtask

  task automatic wait_out(input int k, input string nm);
    int b;
    b = 200;
    while (slog.size() < k && b > 0) begin
      cyc();
      b--;
    end
    chk({nm, "_timeout"}, slog.size() >= k, 1);
  endtask

  task automatic drain(input string nm);
    int b;
    b = 300;
    while ((rem0 != 0 || rem1 != 0 || q.size() != 0) && b > 0) begin
      cyc();
      b--;
    end
    chk({nm, "_drain"}, q.size(), 0);
  endtask

  initial begin
    logic rearm;
    vec[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[2] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    vec[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    vec[4] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    vec[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

    // reset with both requesters asserting, then first grant
    in0_data = 32'h0A00_0000;
    in1_data = 32'h0B00_0000;
    for (int i = 0; i < 6; i++) begin
      rst = vec[i].rst;
      rem0 = vec[i].v0 ? 1000 : 0;
      rem1 = vec[i].v1 ? 1000 : 0;
      out_ready = vec[i].ordy;
      upd();
      cyc();
      chk($sformatf("t1_r0_%0d", i), s_r0, vec[i].r0);
      chk($sformatf("t1_r1_%0d", i), s_r1, vec[i].r1);
      chk($sformatf("t1_ov_%0d", i), s_ov, vec[i].ov);
      if (vec[i].rst) chk($sformatf("t1_od_%0d", i), s_od, 0);
    end

    // single requester, including same-owner re-grant
    do_reset();
    in0_data = 32'hA5A5_0001;
    rem0 = 5;
    upd();
    wait_out(5, "t2");
    for (int i = 0; i < 3; i++)
      chk($sformatf("t2_data_%0d", i), dlog[i], 32'hA5A5_0001 + i);
    for (int i = 1; i < 5; i++) begin
      chk($sformatf("t2_src_%0d", i), slog[i], 0);
      chk($sformatf("t2_gap_%0d", i), tlog[i] - tlog[0], i);
    end
    drain("t2");

    // tie: bursts of four alternate without bubbles
    do_reset();
    in0_data = 32'h1000_0000;
    in1_data = 32'h2000_0000;
    rem0 = 12;
    rem1 = 12;
    upd();
    wait_out(12, "t3");
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("t3_src_%0d", i), slog[i], (i / 4) % 2);
      chk($sformatf("t3_gap_%0d", i), tlog[i] - tlog[0], i);
    end
    drain("t3");

    // backpressure holds data and blocks both readies
    do_reset();
    in0_data = 32'h3000_0000;
    in1_data = 32'h3100_0000;
    rem0 = 8;
    rem1 = 4;
    upd();
    wait_out(2, "t4");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("t4_r0_%0d", i), s_r0, 0);
      chk($sformatf("t4_r1_%0d", i), s_r1, 0);
      chk($sformatf("t4_ov_%0d", i), s_ov, 1);
      chk($sformatf("t4_q_%0d", i), q.size(), 1);
      chk($sformatf("t4_od_%0d", i), s_od,
          q.size() > 0 ? q[0].data : 32'hFFFF_FFFF);
    end
    out_ready = 1'b1;
    drain("t4");
    chk("t4_total", slog.size(), 12);

    // owner drop hands over; the new owner gets a full burst
    do_reset();
    in0_data = 32'h4000_0000;
    in1_data = 32'h5000_0000;
    rem0 = 2;
    rem1 = 8;
    upd();
    rearm = 1'b0;
    for (int b = 0; b < 200 && slog.size() < 10; b++) begin
      cyc();
      if (!rearm && acc1 >= 1) begin
        rem0 = 4;
        upd();
        rearm = 1'b1;
      end
    end
    chk("t5_timeout", slog.size() >= 10, 1);
    for (int i = 0; i < 10; i++)
      chk($sformatf("t5_src_%0d", i), slog[i],
          (i >= 2 && i < 6) ? 1 : 0);
    chk("t5_switch_gap", tlog[6] - tlog[5], 1);
    drain("t5");

    // reset in the middle of an in1 burst
    do_reset();
    in1_data = 32'h6000_0000;
    rem1 = 10;
    upd();
    wait_out(2, "t6");
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    clr();
    in0_data = 32'h7000_0000;
    in1_data = 32'h7100_0000;
    rem0 = 3;
    rem1 = 3;
    upd();
    cyc();
    chk("t6_ov_after_rst", s_ov, 0);
    chk("t6_od_after_rst", s_od, 0);
    wait_out(1, "t6");
    chk("t6_tie_src", slog[0], 0);
    drain("t6");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
